lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Load/store alignment unit sitting directly upstream of the data memory.
- Takes byte, halfword and word requests from the execute stage and drives the memory's word-wide port: Addr, Data_in, Wr_en, combinational Data_out, with the write committed at the clk edge.
- Does read-modify-write for sub-word stores, sign/zero extension for loads, and range checking.
- Splits word-crossing accesses into two word accesses via a small FSM.

Parameters:
- DMEM_BASE, 32'h1001_0000, byte address of first data-memory word (word aligned)
- DMEM_SIZE, 32'h0000_1000, data-memory size in bytes (multiple of 4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid; access aborted
- mem_addr  out  32  word-aligned address to data memory (low 2 bits always 0)
- mem_wdata  out  32  full word to data memory
- mem_we  out  1  write enable to data memory
- mem_rdata  in  32  combinational read data from data memory

Behaviour:
- Reset (async):
  - State goes to IDLE; resp_valid, resp_err, resp_rdata = 0.
  - mem_we = 0 and req_ready = 0 while rst is high.
  - A store half-done when rst rises is not rolled back.
- Byte order: little-endian. Lane k = bits [8k+7:8k]. off = req_addr[1:0]; nbytes = 1, 2 or 4.
- Illegal access, when:
  - req_size = 11, or
  - any touched byte lies outside [DMEM_BASE, DMEM_BASE+DMEM_SIZE), or
  - the access crosses a word and split is disabled.
- Address arithmetic is mod 2^32; 32'hFFFF_FFFE + 4 wraps and is then caught by the range check.
- States: IDLE, HI.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, memory is driven combinationally from the request with mem_addr = {req_addr[31:2], 2'b00}.
  - A store merges req_wdata bytes into mem_rdata at lanes off.., and mem_we = req_valid & req_we & ~illegal.
  - Illegal request: no memory write; next cycle resp_valid = 1, resp_err = 1.
  - Non-crossing (off + nbytes <= 4): completes at the accept edge; resp_valid in the following cycle (latency 1).
  - Crossing (off + nbytes > 4): the low word is handled at the accept edge.
    - Latched: address+4, size, sign mode, wdata and low read bytes.
    - Go to HI.
- HI:
  - req_ready = 0; mem_addr = latched word address + 4.
  - A store merges the remaining upper bytes into lanes 0..; mem_we = 1.
  - A load concatenates the latched low bytes with mem_rdata lanes 0...
  - Next edge: go to IDLE; resp_valid in the following cycle (latency 2).
- Load extension:
  - byte/half sign-extend unless req_unsigned; word ignores req_unsigned.
- Back-to-back:
  - A new request is accepted in the same cycle resp_valid is high.
  - There is no combinational path from req_* to resp_*.
- mem_we never asserts for loads or illegal requests.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN defined: crossing accesses are split as above (HI state present).
- Undefined: crossing accesses are illegal; resp_err = 1 at latency 1, no memory write, HI state absent.
- Non-crossing misaligned accesses (e.g. half at off = 1) are legal and single-cycle in both builds.

Test Plan:
- Preload word 1001_0000 = DEAD_BEEF, word 1001_0004 = 1234_5678. LW 1001_0000 -> resp_valid one cycle after accept, rdata DEAD_BEEF, err 0, mem_we stays 0.
- LB 1001_0003 -> FFFF_FFDE. LBU 1001_0003 -> 0000_00DE. LH 1001_0001 -> FFFF_ADBE.
- SB data 0000_00AA to 1001_0001 -> single mem_we pulse, mem_wdata DEAD_AAEF; then LW 1001_0000 -> DEAD_AAEF.
- LW 1001_0002:
  - With LSU_MISALIGN_SPLIT_EN: mem_addr 1001_0000 then 1001_0004, req_ready low for one cycle, rdata 5678_DEAD at latency 2.
  - Without the macro: resp_err = 1 at latency 1, rdata 0.
- SW 1001_0FFE (crosses DMEM end) and LW 0000_0000 -> resp_err = 1, mem_we never asserted, memory unchanged. req_size = 11 -> resp_err = 1.
- With split: SW 1111_2222 to 1001_0002, rst pulsed during HI:
  - req_ready, resp_valid and mem_we drop immediately.
  - Word 1001_0000 = 2222_BEEF; word 1001_0004 unchanged (1234_5678).
  - After rst release, LW 1001_0000 is serviced normally.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a word-wide data memory with combinational read.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two word accesses (HI state).
module lsu_align #(
    parameter logic [31:0] DMEM_BASE = 32'h1001_0000,
    parameter logic [31:0] DMEM_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic {StIdle, StHi} state_e;
`else
    typedef enum logic {StIdle} state_e;
`endif

    state_e state_q;

    logic [1:0]  off;
    logic [2:0]  nbytes;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [31:0] last_addr;
    logic        in_range;
    logic        crossing;
    logic        illegal;
    logic [31:0] wdata_lo;
    logic [31:0] load_data;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] wdata_hi;
    logic [31:0] addr_hi_q;
    logic [31:0] lo_q;
    logic [31:0] wdata_hi_q;
    logic [3:0]  mask_hi_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] src,
                                          input logic [3:0] mask);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = mask[k] ? src[8*k +: 8] : old[8*k +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                           input logic [31:0] raw);
        case (size)
            2'b00:   return uns ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign off = req_addr[1:0];

    always_comb begin
        case (req_size)
            2'b00:   begin size_mask = 4'b0001; nbytes = 3'd1; end
            2'b01:   begin size_mask = 4'b0011; nbytes = 3'd2; end
            default: begin size_mask = 4'b1111; nbytes = 3'd4; end
        endcase
    end

    // Lanes 7:4 of the shifted mask are the bytes that spill into the next word.
    assign lane_mask = {4'b0000, size_mask} << off;
    assign crossing  = |lane_mask[7:4];
    assign last_addr = req_addr + {29'd0, nbytes} - 32'd1;
    // Offset compares are wrap-safe; the last >= first term rejects accesses wrapping past 2^32.
    assign in_range  = ((req_addr - DMEM_BASE) < DMEM_SIZE)
                     && ((last_addr - DMEM_BASE) < DMEM_SIZE)
                     && (last_addr >= req_addr);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign illegal  = (req_size == 2'b11) || !in_range;
    assign wdata_hi = req_wdata >> (6'd32 - {1'b0, off, 3'b000});
`else
    assign illegal  = (req_size == 2'b11) || !in_range || crossing;
`endif

    assign wdata_lo = req_wdata << {off, 3'b000};

    always_comb begin
        req_ready = ~rst;
        mem_addr  = {req_addr[31:2], 2'b00};
        mem_wdata = merge(mem_rdata, wdata_lo, lane_mask[3:0]);
        mem_we    = req_valid & req_we & ~illegal & ~rst;
        load_data = extend(req_size, req_unsigned, mem_rdata >> {off, 3'b000});
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_q == StHi) begin
            req_ready = 1'b0;
            mem_addr  = addr_hi_q;
            mem_wdata = merge(mem_rdata, wdata_hi_q, mask_hi_q);
            mem_we    = we_q & ~rst;
            // Upper bytes of the latched low word joined with lanes 0.. of the high word.
            load_data = extend(size_q, uns_q, (lo_q >> {off_q, 3'b000})
                               | (mem_rdata << (6'd32 - {1'b0, off_q, 3'b000})));
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            addr_hi_q  <= 32'd0;
            lo_q       <= 32'd0;
            wdata_hi_q <= 32'd0;
            mask_hi_q  <= 4'd0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (illegal) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
`ifdef LSU_MISALIGN_SPLIT_EN
                        else if (crossing) begin
                            state_q    <= StHi;
                            addr_hi_q  <= {req_addr[31:2] + 30'd1, 2'b00};
                            lo_q       <= mem_rdata;
                            wdata_hi_q <= wdata_hi;
                            mask_hi_q  <= lane_mask[7:4];
                            off_q      <= off;
                            size_q     <= req_size;
                            uns_q      <= req_unsigned;
                            we_q       <= req_we;
                        end
`endif
                        else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= req_we ? 32'd0 : load_data;
                        end
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                StHi: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b1;
                    resp_rdata <= we_q ? 32'd0 : load_data;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural word memory; covers both builds
// of LSU_MISALIGN_SPLIT_EN.
module tb_lsu_align;
    localparam logic [31:0] Base = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];
    logic [31:0] moff;
    logic        do_preload = 1'b0;
    int          we_count = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] got_rdata, acc_addr, acc_wdata, hi_addr;
    logic        got_err, hi_ready;
    int          got_lat, got_we;

    lsu_align dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign moff      = mem_addr - Base;
    assign mem_rdata = (moff < 32'h1000) ? mem[moff[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hDEAD_BEEF;
            mem[1] <= 32'h1234_5678;
        end else if (mem_we && moff < 32'h1000) begin
            mem[moff[11:2]] <= mem_wdata;
        end
        if (mem_we) we_count <= we_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload();
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
    endtask

    // Drives one request, waits for accept and then for resp_valid (both bounded).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int we0;
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        got_lat = 0; got_rdata = 32'hX; got_err = 1'bX;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        acc_addr  = mem_addr;
        acc_wdata = mem_wdata;
        we0       = we_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                hi_addr  = mem_addr;
                hi_ready = req_ready;
            end
            if (resp_valid) begin
                got_lat   = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                break;
            end
        end
        got_we = we_count - we0;
    endtask

    task automatic load_ok(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, size, uns, addr, 32'h0);
        check({tag, " rdata"}, got_rdata, exp);
        check({tag, " err"}, {31'd0, got_err}, 32'd0);
        check({tag, " latency"}, got_lat, 32'd1);
        check({tag, " no write"}, got_we, 32'd0);
    endtask

    task automatic expect_err(input string tag, input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        issue(we, size, 1'b0, addr, wdata);
        check({tag, " err"}, {31'd0, got_err}, 32'd1);
        check({tag, " rdata"}, got_rdata, 32'd0);
        check({tag, " latency"}, got_lat, 32'd1);
        check({tag, " no write"}, got_we, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_preload = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = Base;
        @(negedge clk);
        do_preload = 1'b0;
        check("reset req_ready", {31'd0, req_ready}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_err", {31'd0, resp_err}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        load_ok("LW 0000", 2'b10, 1'b0, Base, 32'hDEAD_BEEF);
        load_ok("LB 0003", 2'b00, 1'b0, Base + 3, 32'hFFFF_FFDE);
        load_ok("LBU 0003", 2'b00, 1'b1, Base + 3, 32'h0000_00DE);
        load_ok("LH 0001", 2'b01, 1'b0, Base + 1, 32'hFFFF_ADBE);
        load_ok("LHU 0002", 2'b01, 1'b1, Base + 2, 32'h0000_DEAD);
        load_ok("LW unsigned ignored", 2'b10, 1'b1, Base + 4, 32'h1234_5678);

        issue(1'b1, 2'b00, 1'b0, Base + 1, 32'h0000_00AA);
        check("SB wdata", acc_wdata, 32'hDEAD_AAEF);
        check("SB addr", acc_addr, Base);
        check("SB pulses", got_we, 32'd1);
        check("SB rdata", got_rdata, 32'd0);
        check("SB err", {31'd0, got_err}, 32'd0);
        check("SB latency", got_lat, 32'd1);
        load_ok("LW after SB", 2'b10, 1'b0, Base, 32'hDEAD_AAEF);

`ifdef LSU_MISALIGN_SPLIT_EN
        issue(1'b0, 2'b10, 1'b0, Base + 2, 32'h0);
        check("LW 0002 rdata", got_rdata, 32'h5678_DEAD);
        check("LW 0002 latency", got_lat, 32'd2);
        check("LW 0002 err", {31'd0, got_err}, 32'd0);
        check("LW 0002 addr lo", acc_addr, Base);
        check("LW 0002 addr hi", hi_addr, Base + 4);
        check("LW 0002 ready in HI", {31'd0, hi_ready}, 32'd0);
        check("LW 0002 no write", got_we, 32'd0);
`else
        expect_err("LW 0002", 1'b0, 2'b10, Base + 2, 32'h0);
        expect_err("SW 0002", 1'b1, 2'b10, Base + 2, 32'h1111_2222);
`endif

        issue(1'b1, 2'b01, 1'b0, Base + 1, 32'h0000_1234);
        check("SH 0001 pulses", got_we, 32'd1);
        check("SH 0001 latency", got_lat, 32'd1);
        load_ok("LW after SH", 2'b10, 1'b0, Base, 32'hDE12_34EF);

        expect_err("SW 0FFE", 1'b1, 2'b10, Base + 32'hFFE, 32'hCAFE_F00D);
        expect_err("LW 0", 1'b0, 2'b10, 32'h0, 32'h0);
        expect_err("size 11", 1'b1, 2'b11, Base, 32'hCAFE_F00D);
        expect_err("LB end", 1'b0, 2'b00, Base + 32'h1000, 32'h0);
        expect_err("LB below", 1'b0, 2'b00, Base - 1, 32'h0);
        expect_err("LW wrap", 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0);
        load_ok("LW last word", 2'b10, 1'b0, Base + 32'hFFC, 32'h0);
        check("mem last word intact", mem[1023], 32'h0);
        check("mem word0 intact", mem[0], 32'hDE12_34EF);

        // Back-to-back: second request held valid across the first response cycle.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = Base + 4;
        @(negedge clk);
        @(posedge clk);
        #1 req_size = 2'b00;
        @(negedge clk);
        check("b2b first valid", {31'd0, resp_valid}, 32'd1);
        check("b2b first rdata", resp_rdata, 32'h1234_5678);
        check("b2b ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b second valid", {31'd0, resp_valid}, 32'd1);
        check("b2b second rdata", resp_rdata, 32'h0000_0078);

`ifdef LSU_MISALIGN_SPLIT_EN
        preload();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = Base + 2; req_wdata = 32'h1111_2222;
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("split HI mem_we", {31'd0, mem_we}, 32'd1);
        check("split HI mem_addr", mem_addr, Base + 4);
        rst = 1'b1;
        #1;
        check("rst in HI ready", {31'd0, req_ready}, 32'd0);
        check("rst in HI resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst in HI mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst word0", mem[0], 32'h2222_BEEF);
        check("rst word1", mem[1], 32'h1234_5678);
        @(negedge clk);
        load_ok("LW after rst", 2'b10, 1'b0, Base, 32'h2222_BEEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
